l2arb: RTL

Two-way arbiter that shares the single L2 request port between the icache (read-only line fills) and the dcache request FIFO (reads and masked writes). It registers the winning request into a one-entry output stage toward L2. It also tracks which requester owns each outstanding read, so that in-order L2 read responses are steered back to the correct cache. It sits between `icache`/`l2fifo` and `l2`.

---
 rtl/l2_pkg.sv | 19 +
 rtl/fifo.sv | 67 ++++++
 rtl/l2arb.sv | 127 ++++++++++++
 3 files changed

// File: rtl/l2_pkg.sv
// Shared L2-side types and constants: requester ids and the request payload.
package l2_pkg;

    localparam logic L2_SRC_IC = 1'b0;
    localparam logic L2_SRC_DC = 1'b1;

    localparam int unsigned L2_ADDR_W  = 30;
    localparam int unsigned L2_MASK_W  = 4;
    localparam int unsigned L2_DATA_W  = 32;
    localparam int unsigned L2_REQ_W   = L2_ADDR_W + 1 + L2_MASK_W + L2_DATA_W;

    typedef struct packed {
        logic [L2_ADDR_W-1:0] addr;
        logic                 wen;
        logic [L2_MASK_W-1:0] wmask;
        logic [L2_DATA_W-1:0] wdata;
    } l2_req_t;

endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO; wr_ready is pure not-full (a pop never frees space in the same cycle).
module fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    // Status and head read-out.
    always_comb begin
        wr_ready = (count_q != CW'(DEPTH));
        rd_valid = (count_q != '0);
        rd_data  = mem_q[rd_ptr_q];
    end

    // Pointer, count and storage next-state.
    always_comb begin
        push     = wr_valid && wr_ready;
        pop      = rd_valid && rd_ready;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/l2arb.sv
// Round-robin icache/dcache arbiter into a one-entry L2 request stage, with
// read-ownership tracking to steer in-order L2 read responses.
module l2arb
    import l2_pkg::*;
#(
    parameter int unsigned MAX_OUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_l2arb_req,
    input  logic [31:2] icache_l2arb_addr,
    output logic        l2arb_ic_ready,
    input  logic        l2fifo_l2arb_req,
    input  logic [31:2] l2fifo_l2arb_addr,
    input  logic        l2fifo_l2arb_wen,
    input  logic [3:0]  l2fifo_l2arb_wmask,
    input  logic [31:0] l2fifo_l2arb_wdata,
    output logic        l2arb_l2fifo_ready,
    output logic        l2arb_l2_req,
    output logic [31:2] l2arb_l2_addr,
    output logic        l2arb_l2_wen,
    output logic [3:0]  l2arb_l2_wmask,
    output logic [31:0] l2arb_l2_wdata,
    input  logic        l2_l2arb_ready,
    input  logic        l2_l2arb_resp_valid,
    input  logic [31:0] l2_l2arb_resp_data,
    output logic        l2arb_ic_resp_valid,
    output logic        l2arb_dc_resp_valid,
    output logic [31:0] l2arb_resp_data,
    output logic        l2arb_err
);

    logic    stage_vld_q, stage_vld_d;
    l2_req_t stage_q, stage_d;
    logic    last_q, last_d;
    logic    err_q, err_d;

    logic    q_not_full;
    logic    q_head_vld;
    logic    q_head;
    logic    q_push;
    logic    q_push_src;

    logic    stage_load;
    logic    ic_elig, dc_elig;
    logic    grant_ic, grant_dc;
    logic    ic_acc, dc_acc;

    // Owner queue: one source id per outstanding read, head = oldest.
    fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUT)
    ) u_owner_q (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (q_push),
        .wr_ready (q_not_full),
        .wr_data  (q_push_src),
        .rd_valid (q_head_vld),
        .rd_ready (l2_l2arb_resp_valid),
        .rd_data  (q_head)
    );

    // Eligibility, round-robin grant and ready generation (no payload dependence).
    always_comb begin
        stage_load         = !stage_vld_q || l2_l2arb_ready;
        ic_elig            = icache_l2arb_req && q_not_full;
        dc_elig            = l2fifo_l2arb_req && (l2fifo_l2arb_wen || q_not_full);
        grant_dc           = dc_elig && (!ic_elig || (last_q == L2_SRC_IC));
        grant_ic           = ic_elig && !grant_dc;
        l2arb_ic_ready     = !rst && grant_ic && stage_load;
        l2arb_l2fifo_ready = !rst && grant_dc && stage_load;
        ic_acc             = icache_l2arb_req && l2arb_ic_ready;
        dc_acc             = l2fifo_l2arb_req && l2arb_l2fifo_ready;
        q_push             = ic_acc || (dc_acc && !l2fifo_l2arb_wen);
        q_push_src         = dc_acc ? L2_SRC_DC : L2_SRC_IC;
    end

    // Output stage, last-grant and sticky error next-state.
    always_comb begin
        stage_vld_d = stage_vld_q;
        stage_d     = stage_q;
        last_d      = last_q;
        err_d       = err_q || (l2_l2arb_resp_valid && !q_head_vld);
        if (ic_acc) begin
            stage_vld_d = 1'b1;
            stage_d     = '{addr: icache_l2arb_addr, wen: 1'b0, wmask: '0, wdata: '0};
            last_d      = L2_SRC_IC;
        end else if (dc_acc) begin
            stage_vld_d = 1'b1;
            stage_d     = '{addr: l2fifo_l2arb_addr, wen: l2fifo_l2arb_wen,
                            wmask: l2fifo_l2arb_wmask, wdata: l2fifo_l2arb_wdata};
            last_d      = L2_SRC_DC;
        end else if (l2_l2arb_ready) begin
            stage_vld_d = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_vld_q <= 1'b0;
            stage_q     <= '0;
            last_q      <= L2_SRC_IC;
            err_q       <= 1'b0;
        end else begin
            stage_vld_q <= stage_vld_d;
            stage_q     <= stage_d;
            last_q      <= last_d;
            err_q       <= err_d;
        end
    end

    // Stage outputs and same-cycle response steering.
    always_comb begin
        l2arb_l2_req        = stage_vld_q;
        l2arb_l2_addr       = stage_q.addr;
        l2arb_l2_wen        = stage_q.wen;
        l2arb_l2_wmask      = stage_q.wmask;
        l2arb_l2_wdata      = stage_q.wdata;
        l2arb_err           = err_q;
        l2arb_resp_data     = l2_l2arb_resp_data;
        l2arb_ic_resp_valid = !rst && l2_l2arb_resp_valid && q_head_vld && (q_head == L2_SRC_IC);
        l2arb_dc_resp_valid = !rst && l2_l2arb_resp_valid && q_head_vld && (q_head == L2_SRC_DC);
    end

endmodule
